// File: rtl/tri_setup_if.sv
// Assembler and rasterizer-facing bundle for the triangle setup stage.
// master drives triangles and accept; slave is the setup stage.
interface tri_setup_if;
  logic        tri_ready;
  logic [95:0] vertex_in0;
  logic [95:0] vertex_in1;
  logic [95:0] vertex_in2;
  logic [95:0] color_in0;
  logic [95:0] color_in1;
  logic [95:0] color_in2;
  logic        dequeue;
  logic        setup_valid;
  logic        setup_accept;
  logic [15:0] bbox_xmin;
  logic [15:0] bbox_xmax;
  logic [15:0] bbox_ymin;
  logic [15:0] bbox_ymax;
  logic [16:0] edge_a0;
  logic [16:0] edge_a1;
  logic [16:0] edge_a2;
  logic [16:0] edge_b0;
  logic [16:0] edge_b1;
  logic [16:0] edge_b2;
  logic [32:0] edge_c0;
  logic [32:0] edge_c1;
  logic [32:0] edge_c2;
  logic [31:0] z_out0;
  logic [31:0] z_out1;
  logic [31:0] z_out2;
  logic [95:0] color_out0;
  logic [95:0] color_out1;
  logic [95:0] color_out2;
  logic [15:0] drop_count;

  modport master (
    output tri_ready, vertex_in0, vertex_in1, vertex_in2,
    output color_in0, color_in1, color_in2, setup_accept,
    input  dequeue, setup_valid,
    input  bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax,
    input  edge_a0, edge_a1, edge_a2,
    input  edge_b0, edge_b1, edge_b2,
    input  edge_c0, edge_c1, edge_c2,
    input  z_out0, z_out1, z_out2,
    input  color_out0, color_out1, color_out2, drop_count
  );

  modport slave (
    input  tri_ready, vertex_in0, vertex_in1, vertex_in2,
    input  color_in0, color_in1, color_in2, setup_accept,
    output dequeue, setup_valid,
    output bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax,
    output edge_a0, edge_a1, edge_a2,
    output edge_b0, edge_b1, edge_b2,
    output edge_c0, edge_c1, edge_c2,
    output z_out0, z_out1, z_out2,
    output color_out0, color_out1, color_out2, drop_count
  );
endinterface

// File: rtl/tri_setup.sv
// Triangle setup: edge equations, clipped bbox, winding fix or cull.
// Define CULL_BACKFACE_EN to drop negative-area triangles instead of flipping.
module tri_setup #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input logic       clk,
  input logic       rst_n,
  tri_setup_if.slave bus
);

  localparam logic signed [15:0] XMAX = 16'(SCREEN_W - 1);
  localparam logic signed [15:0] YMAX = 16'(SCREEN_H - 1);

  typedef enum logic [2:0] {
    S_REQ, S_EDGE, S_AREA, S_CLIP, S_OUT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [1:0]               r_k;
  logic signed [15:0]       r_x [3];
  logic signed [15:0]       r_y [3];
  logic [31:0]              r_z [3];
  logic [95:0]              r_col [3];
  logic signed [16:0]       r_a [3];
  logic signed [16:0]       r_b [3];
  logic signed [32:0]       r_c [3];
  logic signed [34:0]       r_area;
  logic signed [15:0]       r_xmin;
  logic signed [15:0]       r_xmax;
  logic signed [15:0]       r_ymin;
  logic signed [15:0]       r_ymax;
  logic                     r_valid;
  logic                     r_deq;
  logic [15:0]              r_drops;

  logic [1:0]               w_j;
  logic signed [31:0]       w_p1;
  logic signed [31:0]       w_p2;
  logic signed [16:0]       w_a;
  logic signed [16:0]       w_b;
  logic signed [32:0]       w_c;
  logic signed [34:0]       w_area;
  logic signed [15:0]       w_cxmin;
  logic signed [15:0]       w_cxmax;
  logic signed [15:0]       w_cymin;
  logic signed [15:0]       w_cymax;
  logic                     w_neg;
  logic                     w_drop;
  logic                     w_unused;

  function automatic logic signed [15:0] min3(
    input logic signed [15:0] a,
    input logic signed [15:0] b,
    input logic signed [15:0] c
  );
    logic signed [15:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [15:0] max3(
    input logic signed [15:0] a,
    input logic signed [15:0] b,
    input logic signed [15:0] c
  );
    logic signed [15:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  assign w_unused = ^{bus.vertex_in0[79:64], bus.vertex_in0[47:32],
                      bus.vertex_in1[79:64], bus.vertex_in1[47:32],
                      bus.vertex_in2[79:64], bus.vertex_in2[47:32]};

  // Edge k against its successor vertex, area sum and clamped bbox.
  always_comb begin
    w_j    = (r_k == 2'd2) ? 2'd0 : r_k + 2'd1;
    w_a    = {r_y[r_k][15], r_y[r_k]} - {r_y[w_j][15], r_y[w_j]};
    w_b    = {r_x[w_j][15], r_x[w_j]} - {r_x[r_k][15], r_x[r_k]};
    w_p1   = r_x[r_k] * r_y[w_j];
    w_p2   = r_x[w_j] * r_y[r_k];
    w_c    = {w_p1[31], w_p1} - {w_p2[31], w_p2};
    w_area = {{2{r_c[0][32]}}, r_c[0]}
           + {{2{r_c[1][32]}}, r_c[1]}
           + {{2{r_c[2][32]}}, r_c[2]};
    w_cxmin = (r_xmin < 16'sd0) ? 16'sd0 : r_xmin;
    w_cymin = (r_ymin < 16'sd0) ? 16'sd0 : r_ymin;
    w_cxmax = (r_xmax > XMAX) ? XMAX : r_xmax;
    w_cymax = (r_ymax > YMAX) ? YMAX : r_ymax;
    w_neg   = r_area[34];
    w_drop  = (r_area == 35'sd0)
            || (w_cxmin > w_cxmax)
            || (w_cymin > w_cymax);
`ifdef CULL_BACKFACE_EN
    w_drop  = w_drop || w_neg;
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_REQ;
    else        r_state <= w_next;
  end

  // Next-state selection.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_REQ:   if (bus.tri_ready) w_next = S_EDGE;
      S_EDGE:  if (r_k == 2'd2) w_next = S_AREA;
      S_AREA:  w_next = S_CLIP;
      S_CLIP:  w_next = w_drop ? S_REQ : S_OUT;
      S_OUT:   if (bus.setup_accept) w_next = S_REQ;
      default: w_next = S_REQ;
    endcase
  end

  // Datapath: capture, per-edge compute, bbox, clip decision, handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k     <= '0;
      r_area  <= '0;
      r_xmin  <= '0;
      r_xmax  <= '0;
      r_ymin  <= '0;
      r_ymax  <= '0;
      r_valid <= 1'b0;
      r_deq   <= 1'b0;
      r_drops <= '0;
      for (int i = 0; i < 3; i++) begin
        r_x[i]   <= '0;
        r_y[i]   <= '0;
        r_z[i]   <= '0;
        r_col[i] <= '0;
        r_a[i]   <= '0;
        r_b[i]   <= '0;
        r_c[i]   <= '0;
      end
    end else begin
      unique case (r_state)
        S_REQ: begin
          if (bus.tri_ready) begin
            r_x[0]   <= bus.vertex_in0[95:80];
            r_x[1]   <= bus.vertex_in1[95:80];
            r_x[2]   <= bus.vertex_in2[95:80];
            r_y[0]   <= bus.vertex_in0[63:48];
            r_y[1]   <= bus.vertex_in1[63:48];
            r_y[2]   <= bus.vertex_in2[63:48];
            r_z[0]   <= bus.vertex_in0[31:0];
            r_z[1]   <= bus.vertex_in1[31:0];
            r_z[2]   <= bus.vertex_in2[31:0];
            r_col[0] <= bus.color_in0;
            r_col[1] <= bus.color_in1;
            r_col[2] <= bus.color_in2;
            r_deq    <= 1'b0;
            r_k      <= 2'd0;
          end else begin
            r_deq    <= 1'b1;
          end
        end
        S_EDGE: begin
          r_a[r_k] <= w_a;
          r_b[r_k] <= w_b;
          r_c[r_k] <= w_c;
          r_k      <= r_k + 2'd1;
        end
        S_AREA: begin
          r_area <= w_area;
          r_xmin <= min3(r_x[0], r_x[1], r_x[2]);
          r_xmax <= max3(r_x[0], r_x[1], r_x[2]);
          r_ymin <= min3(r_y[0], r_y[1], r_y[2]);
          r_ymax <= max3(r_y[0], r_y[1], r_y[2]);
        end
        S_CLIP: begin
          r_xmin <= w_cxmin;
          r_xmax <= w_cxmax;
          r_ymin <= w_cymin;
          r_ymax <= w_cymax;
          if (w_drop) begin
            r_drops <= r_drops + 16'd1;
            r_deq   <= 1'b1;
          end else begin
            r_valid <= 1'b1;
            if (w_neg) begin
              for (int i = 0; i < 3; i++) begin
                r_a[i] <= -r_a[i];
                r_b[i] <= -r_b[i];
                r_c[i] <= -r_c[i];
              end
            end
          end
        end
        S_OUT: begin
          if (bus.setup_accept) begin
            r_valid <= 1'b0;
            r_deq   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Drive the bundle from held registers.
  always_comb begin
    bus.dequeue     = r_deq;
    bus.setup_valid = r_valid;
    bus.bbox_xmin   = r_xmin;
    bus.bbox_xmax   = r_xmax;
    bus.bbox_ymin   = r_ymin;
    bus.bbox_ymax   = r_ymax;
    bus.edge_a0     = r_a[0];
    bus.edge_a1     = r_a[1];
    bus.edge_a2     = r_a[2];
    bus.edge_b0     = r_b[0];
    bus.edge_b1     = r_b[1];
    bus.edge_b2     = r_b[2];
    bus.edge_c0     = r_c[0];
    bus.edge_c1     = r_c[1];
    bus.edge_c2     = r_c[2];
    bus.z_out0      = r_z[0];
    bus.z_out1      = r_z[1];
    bus.z_out2      = r_z[2];
    bus.color_out0  = r_col[0];
    bus.color_out1  = r_col[1];
    bus.color_out2  = r_col[2];
    bus.drop_count  = r_drops;
  end

endmodule

// File: tb/tb_tri_setup.sv
// Bench for tri_setup: scoreboard of expected setup results,
// latency, drop, clip, backpressure and reset checks.
module tb_tri_setup;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tri_setup_if bus ();

  tri_setup dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [2:0][16:0] a;
    logic [2:0][16:0] b;
    logic [2:0][32:0] c;
    logic [63:0]      bbox;
    logic [95:0]      z;
    logic [95:0]      c0;
    logic [95:0]      c1;
    logic [95:0]      c2;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int exp_drops = 0;

  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(
    input int x[3], input int y[3],
    input logic [95:0] zz, input logic [95:0] k0,
    input logic [95:0] k1, input logic [95:0] k2,
    output bit keep
  );
    exp_t e;
    longint av[3], bv[3], cv[3];
    longint area;
    int xmn, xmx, ymn, ymx, jj;
    area = 0;
    for (int k = 0; k < 3; k++) begin
      jj = (k + 1) % 3;
      av[k] = longint'(y[k]) - longint'(y[jj]);
      bv[k] = longint'(x[jj]) - longint'(x[k]);
      cv[k] = longint'(x[k]) * y[jj] - longint'(x[jj]) * y[k];
      area += cv[k];
    end
    xmn = x[0]; xmx = x[0]; ymn = y[0]; ymx = y[0];
    for (int k = 1; k < 3; k++) begin
      if (x[k] < xmn) xmn = x[k];
      if (x[k] > xmx) xmx = x[k];
      if (y[k] < ymn) ymn = y[k];
      if (y[k] > ymx) ymx = y[k];
    end
    if (xmn < 0) xmn = 0;
    if (ymn < 0) ymn = 0;
    if (xmx > 639) xmx = 639;
    if (ymx > 479) ymx = 479;
    keep = (area != 0) && (xmn <= xmx) && (ymn <= ymx);
`ifdef CULL_BACKFACE_EN
    if (area < 0) keep = 0;
`endif
    for (int k = 0; k < 3; k++) begin
      if (area < 0) begin
        av[k] = -av[k]; bv[k] = -bv[k]; cv[k] = -cv[k];
      end
      e.a[k] = av[k][16:0];
      e.b[k] = bv[k][16:0];
      e.c[k] = cv[k][32:0];
    end
    e.bbox = {16'(xmn), 16'(xmx), 16'(ymn), 16'(ymx)};
    e.z = zz;
    e.c0 = k0; e.c1 = k1; e.c2 = k2;
    return e;
  endfunction

  function automatic logic [95:0] vtx(int x, int y, logic [31:0] z);
    return {16'(x), 16'($urandom), 16'(y), 16'($urandom), z};
  endfunction

  task automatic wait_deq();
    int n = 0;
    while (!bus.dequeue && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("deq_wait", 128'(bus.dequeue), 128'(1));
  endtask

  task automatic drive(int x[3], int y[3], output exp_t e, output bit keep);
    logic [31:0] z0, z1, z2;
    logic [95:0] k0, k1, k2;
    z0 = $urandom; z1 = $urandom; z2 = $urandom;
    k0 = {$urandom, $urandom, $urandom};
    k1 = {$urandom, $urandom, $urandom};
    k2 = {$urandom, $urandom, $urandom};
    e = model(x, y, {z2, z1, z0}, k0, k1, k2, keep);
    @(negedge clk);
    bus.vertex_in0 = vtx(x[0], y[0], z0);
    bus.vertex_in1 = vtx(x[1], y[1], z1);
    bus.vertex_in2 = vtx(x[2], y[2], z2);
    bus.color_in0 = k0;
    bus.color_in1 = k1;
    bus.color_in2 = k2;
    bus.tri_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.tri_ready = 1'b0;
    bus.vertex_in0 = {$urandom, $urandom, $urandom};
    bus.color_in0 = '0;
  endtask

  task automatic cmp_out(string tag, exp_t e);
    chk({tag, "_a"}, 128'({bus.edge_a2, bus.edge_a1, bus.edge_a0}), 128'(e.a));
    chk({tag, "_b"}, 128'({bus.edge_b2, bus.edge_b1, bus.edge_b0}), 128'(e.b));
    chk({tag, "_c"}, 128'({bus.edge_c2, bus.edge_c1, bus.edge_c0}), 128'(e.c));
    chk({tag, "_bbox"}, 128'({bus.bbox_xmin, bus.bbox_xmax,
                             bus.bbox_ymin, bus.bbox_ymax}), 128'(e.bbox));
    chk({tag, "_z"}, 128'({bus.z_out2, bus.z_out1, bus.z_out0}), 128'(e.z));
    chk({tag, "_col0"}, 128'(bus.color_out0), 128'(e.c0));
    chk({tag, "_col2"}, 128'(bus.color_out2), 128'(e.c2));
  endtask

  task automatic send(int x0, int y0, int x1, int y1, int x2, int y2, int hold);
    int x[3], y[3];
    int lat, dl;
    exp_t e, got_e;
    bit keep;
    x[0] = x0; x[1] = x1; x[2] = x2;
    y[0] = y0; y[1] = y1; y[2] = y2;
    wait_deq();
    drive(x, y, e, keep);
    if (keep) sb.push_back(e);
    else exp_drops++;
    lat = 0; dl = 0;
    while (!bus.setup_valid && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.dequeue && dl == 0) dl = lat;
    end
    if (bus.setup_valid) begin
      chk("latency", 128'(lat), 128'(5));
      chk("deq_busy", 128'(dl), 128'(0));
      if (sb.size() == 0) begin
        chk("sb_empty", 128'(1), 128'(0));
      end else begin
        got_e = sb.pop_front();
        cmp_out("out", got_e);
        for (int i = 0; i < hold; i++) begin
          @(negedge clk);
          bus.tri_ready = 1'b1;
          bus.vertex_in1 = {$urandom, $urandom, $urandom};
          @(posedge clk);
          #1;
          bus.tri_ready = 1'b0;
          chk("hold_valid", 128'(bus.setup_valid), 128'(1));
          chk("hold_deq", 128'(bus.dequeue), 128'(0));
          if (i == hold - 1) cmp_out("hold", got_e);
        end
        @(negedge clk);
        bus.setup_accept = 1'b1;
        @(posedge clk);
        #1;
        bus.setup_accept = 1'b0;
        chk("acc_valid", 128'(bus.setup_valid), 128'(0));
        chk("acc_deq", 128'(bus.dequeue), 128'(1));
      end
    end else begin
      chk("drop_kept", 128'(keep), 128'(0));
      chk("drop_deq_lat", 128'(dl), 128'(5));
      chk("drop_cnt", 128'(bus.drop_count), 128'(16'(exp_drops)));
    end
  endtask

  initial begin
    int rx[3], ry[3];
    exp_t e;
    bit keep;
    bus.tri_ready = 1'b0;
    bus.setup_accept = 1'b0;
    bus.vertex_in0 = '0;
    bus.vertex_in1 = '0;
    bus.vertex_in2 = '0;
    bus.color_in0 = '0;
    bus.color_in1 = '0;
    bus.color_in2 = '0;
    #12;
    chk("rst_deq", 128'(bus.dequeue), 128'(0));
    chk("rst_valid", 128'(bus.setup_valid), 128'(0));
    chk("rst_drops", 128'(bus.drop_count), 128'(0));
    chk("rst_c0", 128'(bus.edge_c0), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_deq0", 128'(bus.dequeue), 128'(0));
    @(posedge clk);
    #1;
    chk("rel_deq1", 128'(bus.dequeue), 128'(1));

    send(0, 0, 10, 0, 0, 10, 0);
    send(0, 0, 0, 10, 10, 0, 2);
    send(0, 0, 5, 5, 10, 10, 0);
    send(3, 4, 50, 7, 20, 60, 0);
    send(-5, -5, 700, 0, 0, 500, 1);
    send(-20, 0, -5, 10, -10, 20, 0);
    send(100, 100, 200, 150, 120, 300, 10);
    send(700, 10, 800, 20, 750, 90, 0);
    for (int t = 0; t < 6; t++) begin
      send(int'($urandom_range(900)) - 100, int'($urandom_range(700)) - 100,
           int'($urandom_range(900)) - 100, int'($urandom_range(700)) - 100,
           int'($urandom_range(900)) - 100, int'($urandom_range(700)) - 100,
           t % 3);
    end

    wait_deq();
    rx[0] = 1; rx[1] = 30; rx[2] = 5;
    ry[0] = 2; ry[1] = 4; ry[2] = 40;
    drive(rx, ry, e, keep);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_col0", 128'(bus.color_out0), 128'(0));
    chk("mid_z0", 128'(bus.z_out0), 128'(0));
    chk("mid_a", 128'({bus.edge_a2, bus.edge_a1, bus.edge_a0}), 128'(0));
    chk("mid_c", 128'({bus.edge_c2, bus.edge_c1, bus.edge_c0}), 128'(0));
    chk("mid_bbox", 128'({bus.bbox_xmax, bus.bbox_ymax}), 128'(0));
    chk("mid_drops", 128'(bus.drop_count), 128'(0));
    chk("mid_deq", 128'(bus.dequeue), 128'(0));
    chk("mid_valid", 128'(bus.setup_valid), 128'(0));
    exp_drops = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel2_deq0", 128'(bus.dequeue), 128'(0));
    @(posedge clk);
    #1;
    chk("rel2_deq1", 128'(bus.dequeue), 128'(1));
    send(0, 0, 10, 10, 20, 20, 0);
    send(10, 10, 30, 12, 15, 40, 1);

    chk("sb_drained", 128'(sb.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
